seg_scan_driver: RTL

Parametrised time-multiplexed seven-segment driver. It stores a character message of up to MSG_LEN codes and scans NUM_DIGITS common-cathode digits one at a time, translating each code through a shared font. In static mode it shows the first NUM_DIGITS characters. In scroll mode it rotates messages longer than the display across the digits. It sits between the song/menu controller and the board seg/an pins, and is the general replacement for fixed 4-digit, fixed-name display logic.

---
 rtl/seg_pkg.sv | 47 ++++
 rtl/seg_scan_timer.sv | 52 +++++
 rtl/seg_scan_driver.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared character codes, glyph patterns and font lookup for the seven-segment
// scan driver. Glyph bit order is {dp,a,b,c,d,e,f,g}, active-high.
package seg_pkg;

    localparam int CHAR_W_DEF = 6;

    localparam logic [CHAR_W_DEF-1:0]
        CH_0 = 6'd0,  CH_1 = 6'd1,  CH_2 = 6'd2,  CH_3 = 6'd3,  CH_4 = 6'd4,
        CH_5 = 6'd5,  CH_6 = 6'd6,  CH_7 = 6'd7,  CH_8 = 6'd8,  CH_9 = 6'd9,
        CH_A = 6'd10, CH_B = 6'd11, CH_C = 6'd12, CH_D = 6'd13, CH_E = 6'd14,
        CH_F = 6'd15, CH_G = 6'd16, CH_H = 6'd17, CH_I = 6'd18, CH_J = 6'd19,
        CH_K = 6'd20, CH_L = 6'd21, CH_M = 6'd22, CH_N = 6'd23, CH_O = 6'd24,
        CH_P = 6'd25, CH_Q = 6'd26, CH_R = 6'd27, CH_S = 6'd28, CH_T = 6'd29,
        CH_U = 6'd30, CH_V = 6'd31, CH_W = 6'd32, CH_X = 6'd33, CH_Y = 6'd34,
        CH_Z = 6'd35, CH_BLANK = 6'd36, CH_DASH = 6'd37;

    // Letters are approximations; lower-case shapes where upper-case is ambiguous.
    localparam logic [7:0]
        G_0 = 8'h7E, G_1 = 8'h30, G_2 = 8'h6D, G_3 = 8'h79, G_4 = 8'h33,
        G_5 = 8'h5B, G_6 = 8'h5F, G_7 = 8'h70, G_8 = 8'h7F, G_9 = 8'h7B,
        G_A = 8'h77, G_B = 8'h1F, G_C = 8'h4E, G_D = 8'h3D, G_E = 8'h4F,
        G_F = 8'h47, G_G = 8'h5E, G_H = 8'h37, G_I = 8'h06, G_J = 8'h3C,
        G_K = 8'h57, G_L = 8'h0E, G_M = 8'h54, G_N = 8'h15, G_O = 8'h7E,
        G_P = 8'h67, G_Q = 8'h73, G_R = 8'h05, G_S = 8'h5B, G_T = 8'h0F,
        G_U = 8'h3E, G_V = 8'h1C, G_W = 8'h2A, G_X = 8'h37, G_Y = 8'h3B,
        G_Z = 8'h6D, G_BLANK = 8'h00, G_DASH = 8'h01;

    function automatic logic [7:0] font_lookup(input logic [CHAR_W_DEF-1:0] code);
        case (code)
            CH_0: font_lookup = G_0;  CH_1: font_lookup = G_1;  CH_2: font_lookup = G_2;
            CH_3: font_lookup = G_3;  CH_4: font_lookup = G_4;  CH_5: font_lookup = G_5;
            CH_6: font_lookup = G_6;  CH_7: font_lookup = G_7;  CH_8: font_lookup = G_8;
            CH_9: font_lookup = G_9;  CH_A: font_lookup = G_A;  CH_B: font_lookup = G_B;
            CH_C: font_lookup = G_C;  CH_D: font_lookup = G_D;  CH_E: font_lookup = G_E;
            CH_F: font_lookup = G_F;  CH_G: font_lookup = G_G;  CH_H: font_lookup = G_H;
            CH_I: font_lookup = G_I;  CH_J: font_lookup = G_J;  CH_K: font_lookup = G_K;
            CH_L: font_lookup = G_L;  CH_M: font_lookup = G_M;  CH_N: font_lookup = G_N;
            CH_O: font_lookup = G_O;  CH_P: font_lookup = G_P;  CH_Q: font_lookup = G_Q;
            CH_R: font_lookup = G_R;  CH_S: font_lookup = G_S;  CH_T: font_lookup = G_T;
            CH_U: font_lookup = G_U;  CH_V: font_lookup = G_V;  CH_W: font_lookup = G_W;
            CH_X: font_lookup = G_X;  CH_Y: font_lookup = G_Y;  CH_Z: font_lookup = G_Z;
            CH_DASH: font_lookup = G_DASH;
            default: font_lookup = G_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Digit-slot prescaler and scan index. After reset the scan is idle (no digit
// selected); the first prescaler wrap enters digit 0, later wraps advance it.
// step pulses in the first cycle of every slot (the cycle the index is new);
// frame_wrap is the combinational "next edge wraps N-1 -> 0" strobe and
// frame_tick is its registered one-cycle pulse.
module seg_scan_timer #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [IDX_W-1:0] scan_idx,
    output logic             step,
    output logic             frame_wrap,
    output logic             frame_tick
);
    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PRE_W-1:0] pre_cnt;
    logic             running;
    logic             terminal;

    assign terminal   = (pre_cnt == PRE_W'(REFRESH_DIV - 1));
    assign frame_wrap = terminal && running && (scan_idx == IDX_W'(NUM_DIGITS - 1));

    // prescaler, scan index advance and slot/frame pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt    <= '0;
            scan_idx   <= '0;
            running    <= 1'b0;
            step       <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            step       <= terminal;
            frame_tick <= frame_wrap;
            if (terminal) begin
                pre_cnt <= '0;
                if (!running)
                    running <= 1'b1;
                else if (scan_idx == IDX_W'(NUM_DIGITS - 1))
                    scan_idx <= '0;
                else
                    scan_idx <= scan_idx + IDX_W'(1);
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver with a message buffer, static and
// scroll modes. Optional macro SEG_BLINK_EN adds a per-digit blink mask
// driven by a 5-bit frame counter (16 frames on, 16 off).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int MSG_LEN     = 8,
    parameter int CHAR_W      = 6,
    parameter int REFRESH_DIV = 100000,
    parameter int SCROLL_DIV  = 250
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic [MSG_LEN*CHAR_W-1:0]    msg,
    input  logic [$clog2(MSG_LEN+1)-1:0] msg_len,
    input  logic                         scroll_en,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]        blink_mask,
`endif
    output logic [7:0]                   seg,
    output logic [NUM_DIGITS-1:0]        an,
    output logic                         frame_tick
);
    localparam int LEN_W = $clog2(MSG_LEN + 1);
    localparam int SUM_W = LEN_W + 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SCR_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [CHAR_W-1:0] BLANK_CODE = CHAR_W'(CH_BLANK);

    logic [IDX_W-1:0]  scan_idx;
    logic              step;
    logic              frame_wrap;

    logic [CHAR_W-1:0] buf_q [MSG_LEN];
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  offset_q;
    logic [SCR_W-1:0]  scr_cnt_q;

    logic              scroll_act;
    logic              scr_last;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  ch_idx;
    logic              ch_vis;
    logic [CHAR_W-1:0] ch;
    logic [7:0]        glyph;
    logic              blank_now;

    seg_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .REFRESH_DIV(REFRESH_DIV),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .scan_idx  (scan_idx),
        .step      (step),
        .frame_wrap(frame_wrap),
        .frame_tick(frame_tick)
    );

    assign scroll_act = scroll_en && (len_q > LEN_W'(NUM_DIGITS));
    assign scr_last   = (scr_cnt_q == SCR_W'(SCROLL_DIV - 1));

    // message buffer, stored length, scroll counter and offset; load has priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MSG_LEN; k++) buf_q[k] <= BLANK_CODE;
            len_q     <= '0;
            offset_q  <= '0;
            scr_cnt_q <= '0;
        end else if (load) begin
            for (int k = 0; k < MSG_LEN; k++) buf_q[k] <= msg[k*CHAR_W +: CHAR_W];
            len_q     <= (msg_len > LEN_W'(MSG_LEN)) ? LEN_W'(MSG_LEN) : msg_len;
            offset_q  <= '0;
            scr_cnt_q <= '0;
        end else begin
            // stepping on frame_wrap lands the new offset on digit 0 of the new frame
            if (frame_wrap)
                scr_cnt_q <= scr_last ? '0 : scr_cnt_q + SCR_W'(1);
            if (!scroll_act)
                offset_q <= '0;
            else if (frame_wrap && scr_last)
                offset_q <= (offset_q == len_q - LEN_W'(1)) ? '0 : offset_q + LEN_W'(1);
        end
    end

    // character index and code for the digit currently being scanned
    always_comb begin
        sum    = SUM_W'(offset_q) + SUM_W'(scan_idx);
        ch_idx = SUM_W'(scan_idx);
        ch_vis = SUM_W'(scan_idx) < SUM_W'(len_q);
        if (scroll_act) begin
            ch_idx = (sum >= SUM_W'(len_q)) ? sum - SUM_W'(len_q) : sum;
            ch_vis = 1'b1;
        end
        ch = BLANK_CODE;
        for (int k = 0; k < MSG_LEN; k++)
            if (ch_idx == SUM_W'(k)) ch = buf_q[k];
        if (!ch_vis) ch = BLANK_CODE;
        glyph = font_lookup(CHAR_W_DEF'(ch));
    end

`ifdef SEG_BLINK_EN
    logic [4:0] fcnt_q;

    // frame counter whose bit 4 gates blinking digits off
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           fcnt_q <= '0;
        else if (load)       fcnt_q <= '0;
        else if (frame_wrap) fcnt_q <= fcnt_q + 5'd1;
    end

    assign blank_now = blink_mask[scan_idx] & fcnt_q[4];
`else
    assign blank_now = 1'b0;
`endif

    // registered outputs, refreshed once at the start of each digit slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg <= '0;
            an  <= '0;
        end else if (step) begin
            an  <= NUM_DIGITS'(1) << scan_idx;
            seg <= blank_now ? 8'h00 : glyph;
        end
    end

endmodule
